// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter that lets two requesters share one SPI DAC engine.
// One command is in flight at a time; each one ends in a done pulse, with a watchdog abort.
module dac_spi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_in,
    input  logic        rst,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [1:0]  r0_mode,
    input  logic [15:0] r0_wr_infodata,
    input  logic [7:0]  r0_rd_info,
    input  logic [15:0] r0_delay_cnt,
    output logic        r0_done,
    output logic        r0_err,
    output logic [7:0]  r0_rd_data,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [1:0]  r1_mode,
    input  logic [15:0] r1_wr_infodata,
    input  logic [7:0]  r1_rd_info,
    input  logic [15:0] r1_delay_cnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic [7:0]  r1_rd_data,

    output logic [1:0]  eng_mode_sel,
    output logic [15:0] eng_wr_infodata,
    output logic [7:0]  eng_rd_info,
    output logic [15:0] eng_delay_cnt,
    output logic        eng_valid,
    input  logic        eng_ready,
    input  logic [7:0]  eng_rd_data,

    output logic        busy,
    output logic        grant_id,
    output logic        timeout_err
);

    localparam logic [15:0] LAST_CNT     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  MODE_READ    = 2'b01;
    localparam logic [1:0]  MODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, grant_id_q;
    logic [15:0] cnt_q;
    logic [1:0]  eng_mode_q;
    logic [15:0] eng_wr_q, eng_dly_q;
    logic [7:0]  eng_rdi_q;
    logic        eng_valid_q;
    logic [1:0]  done_q, err_q;
    logic [7:0]  rd_data_q [2];
    logic        timeout_q;

    logic        gnt, accept, illegal, eng_done, eng_timeout;
    logic [1:0]  sel_mode;
    logic [15:0] sel_wr, sel_dly;
    logic [7:0]  sel_rdi;

    // A tie goes to whoever did not win last time; a lone requester always wins.
    always_comb begin
        gnt         = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
        sel_mode    = gnt ? r1_mode        : r0_mode;
        sel_wr      = gnt ? r1_wr_infodata : r0_wr_infodata;
        sel_rdi     = gnt ? r1_rd_info     : r0_rd_info;
        sel_dly     = gnt ? r1_delay_cnt   : r0_delay_cnt;
        accept      = (state_q == IDLE) && (r0_valid || r1_valid);
        illegal     = (sel_mode == MODE_ILLEGAL);
        eng_done    = (state_q == WAIT) && eng_ready;
        eng_timeout = (state_q == WAIT) && !eng_ready && (cnt_q == LAST_CNT);
    end

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking (<=) so every register samples pre-edge values regardless of block order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = illegal ? GAP : WAIT;
            WAIT:    if (eng_done || eng_timeout) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r0_ready = accept && !gnt;
        r1_ready = accept && gnt;
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            cnt_q        <= '0;
            eng_mode_q   <= '0;
            eng_wr_q     <= '0;
            eng_rdi_q    <= '0;
            eng_dly_q    <= '0;
            eng_valid_q  <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
            // NOTE: read-back registers are reset too; requesters may read them before any read completes.
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            timeout_q    <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (accept) begin
                grant_id_q   <= gnt;
                last_grant_q <= gnt;
                if (illegal) begin
                    done_q[gnt] <= 1'b1;
                    err_q[gnt]  <= 1'b1;
                end else begin
                    eng_mode_q  <= sel_mode;
                    eng_wr_q    <= sel_wr;
                    eng_rdi_q   <= sel_rdi;
                    eng_dly_q   <= sel_dly;
                    eng_valid_q <= 1'b1;
                    cnt_q       <= '0;
                end
            end else if (eng_done) begin
                eng_valid_q        <= 1'b0;
                done_q[grant_id_q] <= 1'b1;
                if (eng_mode_q == MODE_READ) rd_data_q[grant_id_q] <= eng_rd_data;
            end else if (eng_timeout) begin
                eng_valid_q        <= 1'b0;
                done_q[grant_id_q] <= 1'b1;
                err_q[grant_id_q]  <= 1'b1;
                timeout_q          <= 1'b1;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign eng_mode_sel    = eng_mode_q;
    assign eng_wr_infodata = eng_wr_q;
    assign eng_rd_info     = eng_rdi_q;
    assign eng_delay_cnt   = eng_dly_q;
    assign eng_valid       = eng_valid_q;
    assign r0_done         = done_q[0];
    assign r1_done         = done_q[1];
    assign r0_err          = err_q[0];
    assign r1_err          = err_q[1];
    assign r0_rd_data      = rd_data_q[0];
    assign r1_rd_data      = rd_data_q[1];
    assign grant_id        = grant_id_q;
    assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Bench for dac_spi_arbiter: a timestamp-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dac_spi_arbiter;

    localparam int TMO   = 100;
    localparam int NEVER = 32'h7fffffff;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  r_valid = '0;
    logic [1:0]  r_mode [2];
    logic [15:0] r_wr [2];
    logic [7:0]  r_rdi [2];
    logic [15:0] r_dly [2];
    logic        eng_ready = 1'b0;
    logic [7:0]  eng_rd_data = '0;

    wire [1:0]   r_ready, r_done, r_err;
    wire [7:0]   r0_rd_data, r1_rd_data;
    wire [1:0]   eng_mode_sel;
    wire [15:0]  eng_wr_infodata, eng_delay_cnt;
    wire [7:0]   eng_rd_info;
    wire         eng_valid, busy, grant_id, timeout_err;

    dac_spi_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk_in), .rst(rst),
        .r0_valid(r_valid[0]), .r0_ready(r_ready[0]), .r0_mode(r_mode[0]),
        .r0_wr_infodata(r_wr[0]), .r0_rd_info(r_rdi[0]), .r0_delay_cnt(r_dly[0]),
        .r0_done(r_done[0]), .r0_err(r_err[0]), .r0_rd_data(r0_rd_data),
        .r1_valid(r_valid[1]), .r1_ready(r_ready[1]), .r1_mode(r_mode[1]),
        .r1_wr_infodata(r_wr[1]), .r1_rd_info(r_rdi[1]), .r1_delay_cnt(r_dly[1]),
        .r1_done(r_done[1]), .r1_err(r_err[1]), .r1_rd_data(r1_rd_data),
        .eng_mode_sel(eng_mode_sel), .eng_wr_infodata(eng_wr_infodata),
        .eng_rd_info(eng_rd_info), .eng_delay_cnt(eng_delay_cnt),
        .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_rd_data(eng_rd_data),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: each command is described by its accept cycle and its done cycle.
    bit          model_on = 1'b0;
    int          now = 0;
    int          idle_from = 0;
    int          acc_cyc = -1;
    int          done_cyc = -1;
    bit          m_legal = 1'b0, m_gnt = 1'b0, m_last = 1'b1, m_err = 1'b0, m_to = 1'b0;
    logic [1:0]  m_mode = '0;
    logic [15:0] m_wr = '0, m_dly = '0;
    logic [7:0]  m_rdi = '0;
    logic [7:0]  m_rd [2];
    bit          g;

    always @(posedge clk_in) begin
        if (rst) begin
            model_on = 1'b1;
            idle_from = now + 1;
            acc_cyc = -1;
            done_cyc = -1;
            m_legal = 1'b0; m_gnt = 1'b0; m_last = 1'b1; m_err = 1'b0; m_to = 1'b0;
            m_mode = '0; m_wr = '0; m_dly = '0; m_rdi = '0;
            m_rd[0] = '0; m_rd[1] = '0;
        end else if (model_on) begin
            if (m_legal && done_cyc < 0 && now > acc_cyc) begin
                if (eng_ready) begin
                    done_cyc = now + 1; idle_from = now + 2; m_err = 1'b0;
                    if (m_mode == 2'b01) m_rd[m_gnt] = eng_rd_data;
                end else if (now - acc_cyc - 1 == TMO - 1) begin
                    done_cyc = now + 1; idle_from = now + 2; m_err = 1'b1; m_to = 1'b1;
                end
            end else if (now >= idle_from && r_valid != 2'b00) begin
                g = (r_valid == 2'b11) ? !m_last : r_valid[1];
                m_gnt = g; m_last = g; acc_cyc = now;
                if (r_mode[g] == 2'b11) begin
                    m_legal = 1'b0; done_cyc = now + 1; idle_from = now + 2; m_err = 1'b1;
                end else begin
                    m_legal = 1'b1; done_cyc = -1; idle_from = NEVER;
                    m_mode = r_mode[g]; m_wr = r_wr[g]; m_rdi = r_rdi[g]; m_dly = r_dly[g];
                end
            end
        end
        now++;
    end

    bit       c_idle, c_g, c_ev;
    bit [1:0] c_ready, c_done, c_err;

    always @(negedge clk_in) begin
        if (model_on) begin
            c_idle  = (now >= idle_from);
            c_g     = (r_valid == 2'b11) ? !m_last : r_valid[1];
            c_ready = 2'b00;
            if (c_idle && r_valid != 2'b00) c_ready[c_g] = 1'b1;
            c_ev    = m_legal && acc_cyc >= 0 && now > acc_cyc && (done_cyc < 0 || now < done_cyc);
            c_done  = 2'b00;
            if (done_cyc == now) c_done[m_gnt] = 1'b1;
            c_err   = m_err ? c_done : 2'b00;
            check("cmp_ready", 32'(r_ready), 32'(c_ready));
            check("cmp_done", 32'(r_done), 32'(c_done));
            check("cmp_err", 32'(r_err), 32'(c_err));
            check("cmp_eng_valid", 32'(eng_valid), 32'(c_ev));
            check("cmp_busy", 32'(busy), 32'(!c_idle));
            check("cmp_grant_id", 32'(grant_id), 32'(m_gnt));
            check("cmp_r0_rd_data", 32'(r0_rd_data), 32'(m_rd[0]));
            check("cmp_r1_rd_data", 32'(r1_rd_data), 32'(m_rd[1]));
            check("cmp_timeout_err", 32'(timeout_err), 32'(m_to));
            check("cmp_done_overlap", 32'(r_done == 2'b11), 32'(0));
            if (c_ev) begin
                check("cmp_eng_mode", 32'(eng_mode_sel), 32'(m_mode));
                check("cmp_eng_wr", 32'(eng_wr_infodata), 32'(m_wr));
                check("cmp_eng_rdi", 32'(eng_rd_info), 32'(m_rdi));
                check("cmp_eng_dly", 32'(eng_delay_cnt), 32'(m_dly));
            end
        end
    end

    // Stimulus: one process; step() advances one cycle and runs the engine/requester emulation.
    bit acc0, acc1, rnd_on = 1'b0, eng_auto = 1'b0, ev_prev = 1'b0;
    int k = 0, lat = 0, fixed_lat = 3;

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return int'($urandom_range(0, 30));
        if (r < 16) return TMO - 1;
        if (r == 16) return TMO - 2;
        return TMO + 5;
    endfunction

    task automatic new_cmd(input int n);
        r_valid[n] = 1'b1;
        r_mode[n]  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r_wr[n]    = 16'($urandom);
        r_rdi[n]   = 8'($urandom);
        r_dly[n]   = 16'($urandom);
    endtask

    task automatic drive_req(input int n, input bit accepted);
        if (r_valid[n] && accepted) begin
            r_valid[n] = 1'b0;
            if ($urandom_range(0, 1) == 1) new_cmd(n);
        end else if (r_valid[n]) begin
            if ($urandom_range(0, 31) == 0) r_valid[n] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            new_cmd(n);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        acc0 = r_valid[0] && r_ready[0];
        acc1 = r_valid[1] && r_ready[1];
        @(posedge clk_in);
        #1;
        if (rnd_on) begin
            rst = ($urandom_range(0, 799) == 0);
            drive_req(0, acc0);
            drive_req(1, acc1);
        end
        if (eng_auto) begin
            if (eng_valid && !ev_prev) begin
                k = 0;
                lat = rnd_on ? pick_lat() : fixed_lat;
            end else if (eng_valid) begin
                k++;
            end
            eng_ready   = eng_valid ? (k == lat) : (rnd_on && $urandom_range(0, 7) == 0);
            eng_rd_data = 8'($urandom);
        end
        ev_prev = eng_valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r_valid = 2'b00;
        eng_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    int order [6];
    int n_gr, rem0, rem1, cnt;
    bit seen, seen_err;

    initial begin
        for (int n = 0; n < 2; n++) begin
            r_mode[n] = '0; r_wr[n] = '0; r_rdi[n] = '0; r_dly[n] = '0;
        end
        do_reset();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_eng_valid", 32'(eng_valid), 32'(0));
        check("rst_eng_wr", 32'(eng_wr_infodata), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_rd_data", 32'({r1_rd_data, r0_rd_data}), 32'(0));
        check("rst_done", 32'(r_done), 32'(0));

        // r0 write, engine answers 20 cycles into the wait
        r_mode[0] = 2'b00; r_wr[0] = 16'h1802; r_valid[0] = 1'b1;
        step();
        check("w_accept", 32'(acc0), 32'(1));
        r_valid[0] = 1'b0;
        check("w_eng_valid", 32'(eng_valid), 32'(1));
        check("w_eng_wr", 32'(eng_wr_infodata), 32'(16'h1802));
        check("w_eng_mode", 32'(eng_mode_sel), 32'(0));
        repeat (20) step();
        check("w_eng_valid_held", 32'(eng_valid), 32'(1));
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        check("w_done", 32'(r_done), 32'(2'b01));
        check("w_err", 32'(r_err), 32'(0));
        check("w_eng_valid_low", 32'(eng_valid), 32'(0));
        step();
        check("w_idle", 32'(busy), 32'(0));

        // r1 read returns 8'h07
        r_mode[1] = 2'b01; r_rdi[1] = 8'h99; r_valid[1] = 1'b1;
        step();
        check("r_accept", 32'(acc1), 32'(1));
        r_valid[1] = 1'b0;
        check("r_eng_rdi", 32'(eng_rd_info), 32'(8'h99));
        check("r_grant", 32'(grant_id), 32'(1));
        repeat (5) step();
        eng_ready = 1'b1; eng_rd_data = 8'h07;
        step();
        eng_ready = 1'b0;
        check("r_done", 32'(r_done), 32'(2'b10));
        check("r_rd_data", 32'(r1_rd_data), 32'(8'h07));
        check("r_r0_untouched", 32'(r0_rd_data), 32'(8'h00));
        step();
        check("r_rd_data_hold", 32'(r1_rd_data), 32'(8'h07));

        // both requesters, three commands each, round robin from reset
        do_reset();
        eng_auto = 1'b1; fixed_lat = 3;
        r_mode[0] = 2'b00; r_mode[1] = 2'b10; r_wr[0] = 16'h0123; r_dly[1] = 16'h0040;
        r_valid = 2'b11; rem0 = 3; rem1 = 3; n_gr = 0;
        for (int i = 0; i < 300 && n_gr < 6; i++) begin
            step();
            if (acc0) begin
                if (n_gr < 6) order[n_gr] = 0;
                n_gr++; rem0--;
                if (rem0 == 0) r_valid[0] = 1'b0;
            end
            if (acc1) begin
                if (n_gr < 6) order[n_gr] = 1;
                n_gr++; rem1--;
                if (rem1 == 0) r_valid[1] = 1'b0;
            end
        end
        check("rr_count", 32'(n_gr), 32'(6));
        for (int i = 0; i < 6; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
        repeat (20) step();
        eng_auto = 1'b0; eng_ready = 1'b0;

        // illegal mode never touches the engine
        r_mode[1] = 2'b11; r_valid[1] = 1'b1;
        step();
        check("ill_accept", 32'(acc1), 32'(1));
        r_valid[1] = 1'b0;
        check("ill_done", 32'(r_done), 32'(2'b10));
        check("ill_err", 32'(r_err), 32'(2'b10));
        check("ill_eng_valid", 32'(eng_valid), 32'(0));
        step();
        check("ill_idle", 32'(busy), 32'(0));

        // silent engine: abort after exactly TMO wait cycles
        do_reset();
        r_mode[0] = 2'b00; r_valid[0] = 1'b1;
        step();
        check("to_accept", 32'(acc0), 32'(1));
        r_valid[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300 && eng_valid; i++) begin
            cnt++;
            step();
        end
        check("to_wait_cycles", 32'(cnt), 32'(100));
        check("to_done", 32'(r_done), 32'(2'b01));
        check("to_err", 32'(r_err), 32'(2'b01));
        check("to_flag", 32'(timeout_err), 32'(1));
        repeat (10) step();
        check("to_sticky", 32'(timeout_err), 32'(1));
        do_reset();
        check("to_cleared", 32'(timeout_err), 32'(0));

        // reset five cycles into a wait drops the transaction silently
        r_mode[0] = 2'b01; r_valid[0] = 1'b1;
        step();
        check("rw_accept", 32'(acc0), 32'(1));
        r_valid[0] = 1'b0;
        repeat (5) step();
        check("rw_eng_valid", 32'(eng_valid), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rw_eng_dropped", 32'(eng_valid), 32'(0));
        check("rw_no_done", 32'(r_done), 32'(0));
        step();
        check("rw_no_done_late", 32'(r_done), 32'(0));
        eng_auto = 1'b1; fixed_lat = 4;
        r_mode[0] = 2'b00; r_valid[0] = 1'b1;
        step();
        check("rw_accept2", 32'(acc0), 32'(1));
        r_valid[0] = 1'b0;
        seen = 1'b0; seen_err = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (r_done[0]) begin
                seen = 1'b1;
                seen_err = r_err[0];
            end
        end
        check("rw_done2", 32'(seen), 32'(1));
        check("rw_err2", 32'(seen_err), 32'(0));

        // randomized traffic, model-checked every cycle
        rnd_on = 1'b1;
        repeat (5000) step();
        rnd_on = 1'b0;
        rst = 1'b0;
        r_valid = 2'b00;
        for (int i = 0; i < 400 && busy; i++) step();
        check("drain_idle", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_arbiter.md
DAC_SPI_ARBITER -- requirements
Module: dac_spi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: max cycles WAIT may hold one engine transaction before abort.
REQ-002 clk_in  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 rN_valid  input  1  (N=0,1) requester N holds a command; must stay high and stable until accepted.
REQ-005 rN_ready  output  1  requester N command accepted this cycle when rN_valid&rN_ready.
REQ-006 rN_mode  input  2  00 write, 01 read, 10 delay, 11 illegal.
REQ-007 rN_wr_infodata  input  16  write word: bit15 R/W, bits14:8 address, bits7:0 data.
REQ-008 rN_rd_info  input  8  read header: bit7 R/W, bits6:0 address.
REQ-009 rN_delay_cnt  input  16  delay length for mode 10.
REQ-010 rN_done  output  1  one-cycle pulse: requester N command finished.
REQ-011 rN_err  output  1  qualifies rN_done: command aborted (timeout or illegal mode).
REQ-012 rN_rd_data  output  8  read result, valid from rN_done pulse until next rN_done.
REQ-013 eng_mode_sel / eng_wr_infodata / eng_rd_info / eng_delay_cnt  output  2/16/8/16  registered command to shared SPI engine.
REQ-014 eng_valid  output  1  command valid to engine; held high until completion.
REQ-015 eng_ready  input  1  engine one-cycle completion pulse.
REQ-016 eng_rd_data  input  8  engine read data, sampled on eng_ready.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 grant_id  output  1  requester owning current transaction.
REQ-019 timeout_err  output  1  sticky: set on any timeout, cleared only by rst.

Function
REQ-020 FSM states: IDLE, WAIT, GAP; no other states.
REQ-021 IDLE: rN_ready combinational, high only for the granted requester; both low in WAIT/GAP.
REQ-022 Grant: one valid -> that requester; both valid -> requester != last_grant (round robin).
REQ-023 On accept (cycle T): latch command fields, grant_id, last_grant <= granted; mode 00/01/10 -> WAIT with eng_valid=1 at T+1.
REQ-024 Accept with mode 11: no engine access; GAP at T+1; rN_done=1, rN_err=1 at T+1; rN_rd_data unchanged.
REQ-025 eng_* command outputs stay constant while eng_valid=1.
REQ-026 WAIT: 16-bit counter increments each cycle from 0; eng_ready seen at cycle M -> eng_valid=0, rN_done=1 (N=grant_id), rN_err=0 at M+1; state GAP.
REQ-027 Read mode: rN_rd_data <= eng_rd_data at M+1; write/delay modes leave rN_rd_data unchanged.
REQ-028 Timeout: counter reaching TIMEOUT_CYCLES-1 without eng_ready -> eng_valid=0, rN_done=1, rN_err=1, timeout_err=1 next cycle; state GAP.
REQ-029 eng_ready and timeout on same cycle: completion wins, no error.
REQ-030 eng_ready outside WAIT: ignored.
REQ-031 GAP: exactly one cycle, eng_valid=0, then IDLE; min spacing between engine commands = 2 cycles of eng_valid low.
REQ-032 Back-to-back: requester may assert next valid in cycle of its rN_done; accept no earlier than IDLE cycle after GAP.
REQ-033 rN_done pulses never overlap; at most one per accepted command.
REQ-034 rN_valid dropped before accept: no grant, no side effect.

Reset
REQ-035 rst sampled high: next edge state=IDLE, eng_valid=0, rN_ready by IDLE rule, rN_done=0, rN_err=0, rN_rd_data=0, eng_* command outputs=0, busy=0, grant_id=0, timeout_err=0, counter=0, last_grant=1 (r0 wins first tie).
REQ-036 rst mid-WAIT: transaction dropped, no rN_done pulse.

Verification
REQ-037 r0 write {0,7'h18,8'h02}, engine ready after 20 cycles -> eng_valid 1 cycle after accept, eng_wr_infodata=16'h1802, r0_done=1 r0_err=0 one cycle after eng_ready.
REQ-038 r1 read rd_info 8'h99, eng_rd_data=8'h07 on eng_ready -> r1_rd_data=8'h07 at r1_done, r0 outputs unchanged.
REQ-039 r0,r1 valid same cycle after reset, 3 commands each -> grant order 0,1,0,1,0,1; no overlapping done pulses.
REQ-040 TIMEOUT_CYCLES=100, engine silent -> eng_valid drops after 100 WAIT cycles, r0_done&r0_err=1, timeout_err=1 until rst.
REQ-041 r1 mode 11 -> r1_done&r1_err one cycle after accept, eng_valid stays 0 throughout.
REQ-042 rst asserted 5 cycles into WAIT -> eng_valid=0 next edge, no done pulse; next r0 command completes normally.
